// File: rtl/display_pkg.sv
// Shared constants for the seven-segment display path: active-low glyphs
// for hex 0-F and the four sub-slot encodings of a digit's time slot.
package display_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Sub-slot = phase[1:0]; the phase counts down so LOAD comes first.
    typedef enum logic [1:0] {
        SLOT_GUARD = 2'd0,
        SLOT_ON_B  = 2'd1,
        SLOT_ON_A  = 2'd2,
        SLOT_LOAD  = 2'd3
    } slot_e;

endpackage

// File: rtl/char_to_seg.sv
// Combinational hex-to-seven-segment decoder, active-low, bit order {g..a}.
module char_to_seg
    import display_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (code_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_display_mux.sv
// Four-digit multiplexed seven-segment driver with guarded slots
// (load, on, on, off) per digit and a once-per-frame tick.
module seg_display_mux
    import display_pkg::*;
#(
    parameter int PRESCALE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] c3,
    input  logic [3:0] c2,
    input  logic [3:0] c1,
    input  logic [3:0] c0,
    input  logic       blank,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       frame_tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    phase_q, phase_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          ft_q, ft_d;
    logic          tick;
    slot_e         slot_d;
    logic [1:0]    digit_d;
    logic [3:0]    char_sel;
    logic [6:0]    dec_seg;

    assign tick    = (presc_q == PW'(PRESCALE - 1));
    assign presc_d = tick ? '0 : presc_q + 1'b1;
    assign phase_d = tick ? phase_q - 4'd1 : phase_q;

    // Outputs are a function of the phase being entered, so an/seg move
    // on the same edge as the phase with no extra pipeline stage.
    assign slot_d  = slot_e'(phase_d[1:0]);
    assign digit_d = phase_d[3:2];

    always_comb begin
        char_sel = c0;
        case (digit_d)
            2'd3: char_sel = c3;
            2'd2: char_sel = c2;
            2'd1: char_sel = c1;
            default: char_sel = c0;
        endcase
    end

    char_to_seg u_dec (
        .code_i (char_sel),
        .seg_o  (dec_seg)
    );

    always_comb begin
        seg_d = seg_q;
        if (tick && slot_d == SLOT_LOAD) seg_d = dec_seg;
        an_d = 4'b1111;
        if ((slot_d == SLOT_ON_A || slot_d == SLOT_ON_B) && !blank) an_d[digit_d] = 1'b0;
        ft_d = tick && (phase_q == 4'd0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            phase_q <= 4'd0;
            an_q    <= 4'b1111;
            seg_q   <= SEG_BLANK;
            ft_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            phase_q <= phase_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            ft_q    <= ft_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_tick = ft_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// Bench for seg_display_mux: PRESCALE=4 and PRESCALE=1 instances share stimulus;
// an arithmetic frame model checks every cycle, directed literals pin the model.
module tb_seg_display_mux;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] c3, c2, c1, c0;
    logic       blank;
    logic [3:0] an4, an1;
    logic [6:0] seg4, seg1;
    logic       ft4, ft1;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    seg_display_mux #(.PRESCALE(4)) dut4 (
        .clk(clk), .reset(rst_n), .c3(c3), .c2(c2), .c1(c1), .c0(c0),
        .blank(blank), .an(an4), .seg(seg4), .frame_tick(ft4)
    );

    seg_display_mux #(.PRESCALE(1)) dut1 (
        .clk(clk), .reset(rst_n), .c3(c3), .c2(c2), .c1(c1), .c0(c0),
        .blank(blank), .an(an1), .seg(seg1), .frame_tick(ft1)
    );

    logic [6:0] dectab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: k edges since reset release, T = k/P ticks, phase = -T mod 16.
    int         k      [2];
    int         last_ft[2];
    bit         ft_seen[2];
    logic [6:0] mseg   [2];
    logic [3:0] man    [2];
    logic       mft    [2];
    int         P      [2] = '{4, 1};
    logic [3:0] cs     [4];

    always @(posedge clk) begin
        cs[0] = c0; cs[1] = c1; cs[2] = c2; cs[3] = c3;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                k[i] = 0; mseg[i] = 7'h7f; man[i] = 4'hf; mft[i] = 1'b0; ft_seen[i] = 1'b0;
            end else begin
                int t, ph, s, d;
                bit tk;
                k[i]++;
                tk = (k[i] % P[i]) == 0;
                t  = k[i] / P[i];
                ph = (16 - (t % 16)) % 16;
                s  = ph % 4;
                d  = ph / 4;
                if (tk && s == 3) mseg[i] = dectab[cs[d]];
                man[i] = ((s == 1 || s == 2) && !blank) ? ~(4'b0001 << d) : 4'hf;
                mft[i] = tk && (t % 16 == 1);
            end
        end
        #1;
        chk("model_an_p4", an4, man[0]);
        chk("model_seg_p4", seg4, mseg[0]);
        chk("model_ft_p4", ft4, mft[0]);
        chk("model_an_p1", an1, man[1]);
        chk("model_seg_p1", seg1, mseg[1]);
        chk("model_ft_p1", ft1, mft[1]);
        chk("onehot_an_p4", ($countones(~an4) <= 1), 1);
        chk("onehot_an_p1", ($countones(~an1) <= 1), 1);
        if (rst_n && ft4) begin
            if (ft_seen[0]) chk("ft_period_p4", k[0] - last_ft[0], 64);
            last_ft[0] = k[0]; ft_seen[0] = 1'b1;
        end
        if (rst_n && ft1) begin
            if (ft_seen[1]) chk("ft_period_p1", k[1] - last_ft[1], 16);
            last_ft[1] = k[1]; ft_seen[1] = 1'b1;
        end
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_an4"}, an4, 4'hf);
        chk({tag, "_seg4"}, seg4, 7'h7f);
        chk({tag, "_ft4"}, ft4, 1'b0);
        chk({tag, "_an1"}, an1, 4'hf);
        chk({tag, "_seg1"}, seg1, 7'h7f);
    endtask

    logic [6:0] frame_seg [4] = '{7'b0000000, 7'b1000000, 7'b0001110, 7'b0000011};
    logic [3:0] frame_an  [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    initial begin
        rst_n = 1'b0; blank = 1'b0;
        c3 = 4'h0; c2 = 4'h0; c1 = 4'h0; c0 = 4'h0;
        edges(3);
        chk_reset_vals("reset");
        #1;
        c3 = 4'h1; c2 = 4'h2; c1 = 4'h3; c0 = 4'h4;
        rst_n = 1'b1;

        edges(3);
        chk("e3_an", an4, 4'b1111);
        chk("e3_seg", seg4, 7'h7f);
        edges(1);
        chk("e4_seg", seg4, 7'b1111001);
        chk("e4_an", an4, 4'b1111);
        chk("e4_ft", ft4, 1'b1);
        edges(4);
        chk("e8_an", an4, 4'b0111);
        edges(8);
        chk("e16_an", an4, 4'b1111);
        edges(4);
        chk("e20_seg", seg4, 7'b0100100);
        chk("e20_an", an4, 4'b1111);

        c3 = 4'h8; c2 = 4'h0; c1 = 4'hF; c0 = 4'hB;
        edges(48);
        chk("e68_ft", ft4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("frame_load_seg", seg4, frame_seg[i]);
            edges(4);
            chk("frame_on_an", an4, frame_an[i]);
            edges(12);
        end

        c2 = 4'h5;
        edges(16);
        chk("c2_load5", seg4, 7'b0010010);
        edges(4);
        chk("c2_on_an", an4, 4'b1011);
        c2 = 4'h6;
        edges(1);
        chk("c2_hold", seg4, 7'b0010010);
        edges(59);
        chk("c2_load6", seg4, 7'b0000010);

        edges(21);
        chk("blank_pre_an", an4, 4'b1101);
        blank = 1'b1;
        edges(1);
        chk("blank_on_an", an4, 4'b1111);
        edges(2);
        chk("blank_hold_an", an4, 4'b1111);
        blank = 1'b0;
        edges(1);
        chk("blank_off_an", an4, 4'b1101);
        edges(3);
        chk("blank_guard_an", an4, 4'b1111);
        edges(4);
        chk("blank_next_seg", seg4, 7'b0000011);

        edges(36);
        chk("rst_pre_an", an4, 4'b1011);
        #1 rst_n = 1'b0;
        #1 chk_reset_vals("async_rst");
        edges(2);
        rst_n = 1'b1;
        edges(3);
        chk("rel_e3_seg", seg4, 7'h7f);
        chk("rel_e3_an", an4, 4'hf);
        edges(1);
        chk("rel_e4_seg", seg4, 7'b0000000);

        for (int n = 0; n < 2500; n++) begin
            edges(1);
            #1;
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 3))
                    0: c0 = 4'($urandom);
                    1: c1 = 4'($urandom);
                    2: c2 = 4'($urandom);
                    default: c3 = 4'($urandom);
                endcase
            end
            if (blank) blank = ($urandom_range(0, 2) != 0);
            else       blank = ($urandom_range(0, 24) == 0);
            if (n == 1200) begin
                rst_n = 1'b0;
                #1 chk_reset_vals("rand_rst");
                edges(1);
                rst_n = 1'b1;
            end
        end

        edges(2);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/seg_display_mux.md
# seg_display_mux

Time-multiplexed four-digit seven-segment driver that takes the four 4-bit character codes produced by the text scroll stage (c3..c0) and drives the shared segment bus and per-digit anodes of the board display. Each digit gets a guarded time slot (load, on, on, off) so that ghosting between neighbouring digits cannot occur. A once-per-frame pulse is also provided as the timebase for the upstream scroll counter.

## Interface
- PRESCALE, default 16: clock cycles per phase tick; legal range ≥ 1.
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- c3, c2, c1, c0  input  4 each  character codes; c3 goes to the leftmost digit (an[3]), c0 to the rightmost (an[0]).
- blank  input  1  forces all anodes off while high; counters keep running.
- an  output  4  active-low anode enables, registered.
- seg  output  7  active-low segments, registered; seg[0]=a … seg[6]=g.
- frame_tick  output  1  one-cycle pulse, registered, once per full 16-phase frame.

## Operation
- Prescaler counts 0..PRESCALE-1. tick is asserted on the cycle where it equals PRESCALE-1; it then wraps to 0. When PRESCALE=1, tick is asserted every cycle.
- phase is a 4-bit down-counter that decrements on tick and wraps 0→15.
- Digit index d = phase[3:2]; sub-slot s = phase[1:0].
- s=3 (load): all anodes off. seg ← decode(c_d), sampled on the edge entering this phase.
- s=2, s=1 (on): an[d]=0 and the other anodes are 1, unless blank=1, in which case all anodes are 1.
- s=0 (guard): all anodes off. seg is held.
- seg is loaded only in the load slot. Changes on c3..c0 at any other time have no visible effect until that digit's next load slot, so the display is glitch-free.
- Decode is standard hex, 0–F, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - Bit order is {g,f,e,d,c,b,a}.
- frame_tick is asserted for exactly one cycle, in the cycle after the edge where phase wraps 0→15.

## Timing
- Reset values: prescaler=0, phase=0, an=4'b1111, seg=7'b1111111, frame_tick=0.
- First tick occurs on the PRESCALE-th rising edge after reset release. On that edge phase becomes 15, seg ← decode(c3), and an stays 1111.
- an and seg update on the same edge that updates phase. No extra pipeline stage; latency from tick to outputs is 0 cycles.
- Digit on-time is 2·PRESCALE cycles. Frame length is 16·PRESCALE cycles. frame_tick period equals the frame length.
- blank is sampled every cycle. Assertion mid-slot turns anodes off on the next edge; deassertion in an on-slot re-enables an[d] on the next edge.
- Reset asserted mid-frame forces every output to its reset value immediately (asynchronous). The frame restarts from phase=0.
- At most one anode is low at any time. Consecutive active digits are separated by at least 2·PRESCALE cycles with all anodes off.

## Structure
- Shared package (display_pkg) holds:
  - the SEG_* active-low constants for 0–F;
  - SEG_BLANK = 7'b1111111;
  - the sub-slot encodings SLOT_LOAD=2'd3, SLOT_ON_A=2'd2, SLOT_ON_B=2'd1, SLOT_GUARD=2'd0.
- One sub-module, char_to_seg: purely combinational, 4-bit code in, 7-bit active-low segments out. seg_display_mux registers its output.

## Test plan
- Reset, then release with PRESCALE=4, c3..c0 = 1,2,3,4:
  - an=1111 and seg=1111111 until edge 4.
  - At edge 4, seg=1111001 with an=1111.
  - At edge 8, an=0111.
  - At edge 16, an=1111.
  - At edge 20, seg=0100100 and an=1111.
- Full frame with c = 8,0,F,b: observe load-slot seg values 0000000, 1000000, 0001110, 0000011 in that order. Check the anode sequence 0111, 1011, 1101, 1110, and that no two anodes are ever low together.
- Change c2 from 5 to 6 while an[2]=0: seg stays 0010010 until c2's next load slot, then becomes 0000010.
- Assert blank for 3 cycles during digit 1's on-slot: an goes to 1111 on the next edge and returns to 1101 one edge after deassertion. Phase timing is unaffected.
- frame_tick: with PRESCALE=4, pulses are exactly 64 cycles apart and each is 1 cycle wide. With PRESCALE=1, pulses are 16 cycles apart.
- Assert reset during digit 2's on-slot: outputs go to reset values without waiting for a clock edge. After release, the first load is again digit 3, PRESCALE edges later.
